button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 1000000, meaning the consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range is DEB_CYCLES >= 2.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100000000, meaning the consecutive debounced-high cycles before long_press fires (1 s at 100 MHz); legal range is LONG_CYCLES >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port btn_in, input, 1 bit: raw pushbutton, active-high, asynchronous to clk, bouncing.
REQ-006 The block SHALL have port btn_level, output, 1 bit: debounced button level, registered.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: one-cycle pulse on accepted 0->1 change.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: one-cycle pulse on accepted 1->0 change.
REQ-009 The block SHALL have port long_press, output, 1 bit: one-cycle pulse after a held press (see Configuration).

Function
REQ-010 The block SHALL synchronize btn_in through two flops; the second flop output is "s". No other logic SHALL sample btn_in.
REQ-011 The FSM SHALL have exactly the states STABLE_LOW, WAIT_HIGH, STABLE_HIGH and WAIT_LOW.
REQ-012 In STABLE_LOW with s=1, the FSM SHALL go to WAIT_HIGH and clear the debounce counter to 0; in STABLE_HIGH with s=0, it SHALL go to WAIT_LOW and clear the counter.
REQ-013 In WAIT_x with s equal to the candidate level and the counter below DEB_CYCLES-1, the counter SHALL increment by 1.
REQ-014 In WAIT_x with s equal to the candidate level and the counter equal to DEB_CYCLES-1, the FSM SHALL enter STABLE_x, update btn_level, and assert the matching pulse for exactly one cycle.
REQ-015 In WAIT_x with s not equal to the candidate level, the FSM SHALL return to the previous stable state and clear the counter; no pulse and no btn_level change SHALL occur.
REQ-016 Latency: when btn_in is held at a new value from clock edge 0 (the first edge sampling it), btn_level and the pulse SHALL change at edge DEB_CYCLES+2.
REQ-017 press_pulse and release_pulse SHALL never be asserted in the same cycle; each SHALL be asserted in the same cycle btn_level changes.
REQ-018 Counters SHALL be sized for max(DEB_CYCLES, LONG_CYCLES)-1 and SHALL never wrap.

Reset
REQ-019 rst_n=0 SHALL immediately force: both synchronizer flops to 0, state to STABLE_LOW, all counters to 0, and btn_level, press_pulse, release_pulse and long_press to 0.
REQ-020 Reset asserted mid-debounce or mid-hold SHALL discard all progress; no pulse SHALL be emitted due to the reset.
REQ-021 If btn_in is high when rst_n deasserts, press_pulse SHALL fire per REQ-016, counted from the first post-reset edge.

Configuration
REQ-022 The macro BUTTON_DEBOUNCE_LONGPRESS_EN SHALL control the long-press feature.
REQ-023 With BUTTON_DEBOUNCE_LONGPRESS_EN defined:
- the hold counter SHALL clear on entry to STABLE_HIGH;
- it SHALL increment each cycle in STABLE_HIGH and saturate at LONG_CYCLES-1;
- long_press SHALL pulse for one cycle on the cycle the counter reaches LONG_CYCLES-1, at most once per press;
- leaving STABLE_HIGH (including via WAIT_LOW) SHALL NOT reset the once-per-press latch until STABLE_LOW is reached.
REQ-024 Without BUTTON_DEBOUNCE_LONGPRESS_EN, the hold counter SHALL be absent, long_press SHALL be constant 0, and all other behaviour SHALL be identical.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, macro defined)
REQ-025 Clean press: btn_in 0->1 held, first sampled at edge 0 -> btn_level=1 and press_pulse=1 at edge 6 only.
REQ-026 Bounce: btn_in pattern 1,0,1,1,0 at one-cycle spacing, then held 1 -> exactly one press_pulse, 6 edges after the final 0->1 is first sampled; btn_level never toggles early.
REQ-027 Glitch: a single 3-cycle-high btn_in pulse from STABLE_LOW -> no press_pulse or release_pulse; btn_level stays 0.
REQ-028 Release and long press:
- hold btn_level=1 for 30 cycles -> exactly one long_press, 19 edges after entering STABLE_HIGH;
- then release -> release_pulse 6 edges after 1->0 is sampled.
REQ-029 Reset mid-operation: rst_n=0 for 2 cycles while in WAIT_HIGH with counter=2 -> all outputs 0 during reset; with btn_in still 1, press_pulse fires at post-reset edge 6.
REQ-030 Macro undefined: rerun REQ-028 -> long_press remains 0; all other pulse timings are unchanged.

Source files
------------

// File: rtl/button_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer, 4-state debounce FSM, press/release pulses.
// Define BUTTON_DEBOUNCE_LONGPRESS_EN to build the long_press hold detector.
module button_debounce #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int MAXC = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    logic [1:0]    sync_q;
    logic          s;
    state_t        state_q;
    logic [CW-1:0] deb_q;
    logic          level_q;
    logic          press_q;
    logic          rel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_in};
        end
    end

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LOW;
            deb_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state_q)
                STABLE_LOW: begin
                    if (s) begin
                        state_q <= WAIT_HIGH;
                        deb_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_q <= STABLE_LOW;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q <= STABLE_HIGH;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        deb_q <= deb_q + CW'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state_q <= WAIT_LOW;
                        deb_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_q <= STABLE_HIGH;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q <= STABLE_LOW;
                        level_q <= 1'b0;
                        rel_q   <= 1'b1;
                    end else begin
                        deb_q <= deb_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    deb_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] LONG_PRE  = CW'(LONG_CYCLES - 2);

    logic [CW-1:0] hold_q;
    logic          fired_q;
    logic          long_q;
    logic          enter_high;

    // Any transition into STABLE_HIGH, including a bounce back out of WAIT_LOW
    assign enter_high = ((state_q == WAIT_HIGH) && s && (deb_q == DEB_LAST)) ||
                        ((state_q == WAIT_LOW) && s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (enter_high) begin
                hold_q <= '0;
            end else if (state_q == STABLE_HIGH && hold_q != LONG_LAST) begin
                hold_q <= hold_q + CW'(1);
                if (hold_q == LONG_PRE && !fired_q) begin
                    long_q  <= 1'b1;
                    fired_q <= 1'b1;
                end
            end
            if (state_q == STABLE_LOW) begin
                fired_q <= 1'b0;
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (DEB_CYCLES=4, LONG_CYCLES=20).
// Expected outputs are queued as each cycle is driven and compared after the edge.
module tb_button_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 20;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam logic LP = 1'b1;
`else
    localparam logic LP = 1'b0;
`endif

    typedef struct packed {
        logic lvl;
        logic pr;
        logic rl;
        logic lp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    button_debounce #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    always #5 clk = ~clk;

    task automatic check_pop(string tag);
        exp_t e;
        exp_t a;
        e = sb.pop_front();
        a = {btn_level, press_pulse, release_pulse, long_press};
        n_chk++;
        assert (a === e) else begin
            n_fail++;
            $error("FAIL %s: lvl/press/rel/long got %b expected %b", tag, a, e);
        end
    endtask

    task automatic cyc(logic b, logic l, logic p, logic r, logic lp, string tag);
        btn_in = b;
        sb.push_back(exp_t'({l, p, r, lp & LP}));
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    task automatic chk_zero_now(string tag);
        sb.push_back(exp_t'(4'b0000));
        #1;
        check_pop(tag);
    endtask

    task automatic release_seq(string tag);
        for (int k = 0; k < 10; k++)
            cyc(1'b0, k < 6, 1'b0, k == 6, 1'b0, $sformatf("%s[%0d]", tag, k));
    endtask

    initial begin
        logic [4:0] pat;

        // Reset state, including a high button while reset is held
        repeat (3) @(posedge clk);
        chk_zero_now("reset");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_btn1");
        btn_in = 1'b0;
        rst_n  = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("idle[%0d]", k));

        // Clean press, long hold, one-cycle dip, second hold, release
        for (int k = 0; k < 73; k++)
            cyc(k < 63 && k != 37, k >= 6 && k < 69, k == 6, k == 69, k == 25,
                $sformatf("hold[%0d]", k));
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("idle2[%0d]", k));

        // Bounce 1,0,1,1,0 then held high
        pat = 5'b01101;
        for (int k = 0; k < 15; k++)
            cyc(k < 5 ? pat[k] : 1'b1, k >= 11, k == 11, 1'b0, 1'b0,
                $sformatf("bounce[%0d]", k));
        release_seq("bounce_rel");

        // Short pulses: 3 and 4 cycles rejected, 5 cycles accepted
        for (int k = 0; k < 13; k++)
            cyc(k < 3, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("glitch3[%0d]", k));
        for (int k = 0; k < 13; k++)
            cyc(k < 4, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("glitch4[%0d]", k));
        for (int k = 0; k < 15; k++)
            cyc(k < 5, k >= 6 && k < 11, k == 6, k == 11, 1'b0,
                $sformatf("pulse5[%0d]", k));

        // Reset while in WAIT_HIGH with counter at 2
        for (int k = 0; k < 5; k++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("mid[%0d]", k));
        rst_n = 1'b0;
        chk_zero_now("rst_mid_async");
        for (int k = 0; k < 2; k++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("rst_mid[%0d]", k));
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++)
            cyc(1'b1, k >= 6, k == 6, 1'b0, 1'b0, $sformatf("post_rst[%0d]", k));

        // Reset while btn_level is high clears it at once
        rst_n = 1'b0;
        chk_zero_now("rst_high_async");
        for (int k = 0; k < 2; k++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("rst_high[%0d]", k));
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++)
            cyc(1'b1, k >= 6, k == 6, 1'b0, 1'b0, $sformatf("post_rst2[%0d]", k));
        release_seq("final_rel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
